// File: rtl/sequential_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first.
// Shares the ab_valid/ab_ready request and z_valid/z_ready result handshake with the multiplier.
module sequential_div #(
  parameter int Dividend_length = 8,
  parameter int Divisor_length  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Dividend_length-1:0] a,
  input  logic [Divisor_length-1:0]  b,
  input  logic                       ab_valid,
  output logic                       ab_ready,
  output logic [Dividend_length-1:0] q,
  output logic [Divisor_length-1:0]  r,
  output logic                       div_by_zero,
  output logic                       z_valid,
  input  logic                       z_ready
);

  localparam int CntW = $clog2(Dividend_length + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e                     state_q,    state_d;
  logic                       ab_ready_q, ab_ready_d;
  logic                       z_valid_q,  z_valid_d;
  logic [Dividend_length-1:0] q_q,        q_d;
  logic [Divisor_length-1:0]  r_q,        r_d;
  logic                       dbz_q,      dbz_d;
  logic [Dividend_length-1:0] dividend_q, dividend_d;
  logic [Divisor_length-1:0]  divisor_q,  divisor_d;
  logic [Divisor_length:0]    rem_q,      rem_d;
  logic [Dividend_length-1:0] quot_q,     quot_d;
  logic [CntW-1:0]            count_q,    count_d;

  // One restoring step. The remainder stays below the divisor, so the shifted
  // value fits in Divisor_length+1 bits; one more bit carries the trial sign.
  logic [Divisor_length:0]    rem_shift;
  logic [Divisor_length+1:0]  trial;
  logic                       q_bit;
  logic [Divisor_length:0]    rem_next;
  logic [Dividend_length-1:0] quot_next;

  assign rem_shift = {rem_q[Divisor_length-1:0], dividend_q[Dividend_length-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, divisor_q};
  assign q_bit     = ~trial[Divisor_length+1];
  assign rem_next  = q_bit ? trial[Divisor_length:0] : rem_shift;
  assign quot_next = {quot_q[Dividend_length-2:0], q_bit};

  always_comb begin
    // NOTE: every _d takes its held value first so no path through the case leaves one unassigned (no latch).
    state_d    = state_q;
    ab_ready_d = ab_ready_q;
    z_valid_d  = z_valid_q;
    q_d        = q_q;
    r_d        = r_q;
    dbz_d      = dbz_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    count_d    = count_q;

    unique case (state_q)
      IDLE: begin
        ab_ready_d = 1'b1;
        if (ab_valid && ab_ready_q) begin
          ab_ready_d = 1'b0;
          dividend_d = a;
          divisor_d  = b;
          rem_d      = '0;
          quot_d     = '0;
          count_d    = CntW'(Dividend_length);
          if (b != '0) begin
            state_d = CALC;
          end else begin
            // The flagged result is loaded now; z_valid follows on the next edge.
            state_d = DONE;
            q_d     = '1;
            r_d     = '0;
            dbz_d   = 1'b1;
          end
        end
      end

      CALC: begin
        dividend_d = dividend_q << 1;
        rem_d      = rem_next;
        quot_d     = quot_next;
        count_d    = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          state_d   = DONE;
          q_d       = quot_next;
          r_d       = rem_next[Divisor_length-1:0];
          dbz_d     = 1'b0;
          z_valid_d = 1'b1;
        end
      end

      DONE: begin
        z_valid_d = 1'b1;
        // Release only a result that has actually been presented.
        if (z_valid_q && z_ready) begin
          z_valid_d  = 1'b0;
          ab_ready_d = 1'b1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d    = IDLE;
        ab_ready_d = 1'b0;
        z_valid_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ab_ready_q <= 1'b0;
      z_valid_q  <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      dbz_q      <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ab_ready_q <= ab_ready_d;
      z_valid_q  <= z_valid_d;
      q_q        <= q_d;
      r_q        <= r_d;
      dbz_q      <= dbz_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      count_q    <= count_d;
    end
  end

  assign ab_ready    = ab_ready_q;
  assign z_valid     = z_valid_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_div.sv
// Self-checking bench for sequential_div: vector table plus corner-case sequences,
// with expected results queued at issue and compared when z_valid appears.
module tb_sequential_div;

  localparam int DL = 8;
  localparam int VL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DL-1:0] a;
  logic [VL-1:0] b;
  logic          ab_valid;
  logic          ab_ready;
  logic [DL-1:0] q;
  logic [VL-1:0] r;
  logic          div_by_zero;
  logic          z_valid;
  logic          z_ready;

  always #5 clk = ~clk;

  sequential_div #(
    .Dividend_length(DL),
    .Divisor_length (VL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .ab_valid   (ab_valid),
    .ab_ready   (ab_ready),
    .q          (q),
    .r          (r),
    .div_by_zero(div_by_zero),
    .z_valid    (z_valid),
    .z_ready    (z_ready)
  );

  typedef struct {
    logic [DL-1:0] a;
    logic [VL-1:0] b;
    logic [DL-1:0] q;
    logic [VL-1:0] r;
    logic          dbz;
    int            hold;
    bit            toggle;
  } vec_t;

  typedef struct {
    logic [DL-1:0] q;
    logic [VL-1:0] r;
    logic          dbz;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ab_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " ab_ready before issue"}, 32'(ab_ready), 32'd1);
  endtask

  task automatic run_op(input vec_t v, input string name);
    exp_t e;
    int   lat;
    wait_ready(name);
    a        = v.a;
    b        = v.b;
    ab_valid = 1'b1;
    z_ready  = 1'b0;
    sb.push_back('{v.q, v.r, v.dbz, (v.b == '0) ? 1 : DL});
    @(negedge clk);
    ab_valid = 1'b0;
    lat      = 0;
    check({name, " ab_ready dropped"}, 32'(ab_ready), 32'd0);
    while (z_valid !== 1'b1 && lat < 40) begin
      if (v.toggle) begin
        check({name, " no accept while busy"}, 32'(ab_ready), 32'd0);
        a        = DL'($urandom);
        b        = VL'($urandom);
        ab_valid = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    ab_valid = 1'b0;
    e = sb.pop_front();
    check({name, " latency"}, 32'(lat), 32'(e.lat));
    check({name, " q"}, 32'(q), 32'(e.q));
    check({name, " r"}, 32'(r), 32'(e.r));
    check({name, " div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check({name, " held z_valid"}, 32'(z_valid), 32'd1);
      check({name, " held q/r"}, 32'({q, r}), 32'({e.q, e.r}));
      check({name, " held div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
    end
    z_ready = 1'b1;
    @(negedge clk);
    z_ready = 1'b0;
    check({name, " z_valid after release"}, 32'(z_valid), 32'd0);
    check({name, " ab_ready after release"}, 32'(ab_ready), 32'd1);
  endtask

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0] = '{8'd200, 4'd7,  8'd28,  4'd4, 1'b0, 0, 1'b0};
    tbl[1] = '{8'd255, 4'd15, 8'd17,  4'd0, 1'b0, 0, 1'b0};
    tbl[2] = '{8'd5,   4'd9,  8'd0,   4'd5, 1'b0, 0, 1'b0};
    tbl[3] = '{8'd0,   4'd3,  8'd0,   4'd0, 1'b0, 0, 1'b0};
    tbl[4] = '{8'd255, 4'd1,  8'd255, 4'd0, 1'b0, 5, 1'b0};
    tbl[5] = '{8'd100, 4'd0,  8'd255, 4'd0, 1'b1, 2, 1'b0};
    tbl[6] = '{8'd100, 4'd3,  8'd33,  4'd1, 1'b0, 0, 1'b1};
    tbl[7] = '{8'd99,  4'd10, 8'd9,   4'd9, 1'b0, 0, 1'b0};

    rst      = 1'b1;
    ab_valid = 1'b1;
    a        = 8'd200;
    b        = 4'd7;
    z_ready  = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("outputs in reset", 32'({ab_ready, z_valid, div_by_zero, q, r}), 32'd0);
    end
    rst = 1'b0;
    check("ab_ready before first edge", 32'(ab_ready), 32'd0);
    @(negedge clk);
    check("ab_ready one edge after reset", 32'(ab_ready), 32'd1);
    check("z_valid idle", 32'(z_valid), 32'd0);
    ab_valid = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i], $sformatf("vec%0d %0d/%0d", i, tbl[i].a, tbl[i].b));
    end

    for (int i = 0; i < 12; i++) begin
      v.a      = DL'($urandom);
      v.b      = VL'($urandom_range(0, 15));
      v.q      = (v.b == '0) ? '1 : DL'(int'(v.a) / int'(v.b));
      v.r      = (v.b == '0) ? '0 : VL'(int'(v.a) % int'(v.b));
      v.dbz    = (v.b == '0);
      v.hold   = i % 3;
      v.toggle = (i % 2 == 1);
      run_op(v, $sformatf("rand%0d %0d/%0d", i, v.a, v.b));
    end

    wait_ready("abort");
    a        = 8'd200;
    b        = 4'd7;
    ab_valid = 1'b1;
    @(negedge clk);
    ab_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort outputs cleared", 32'({ab_ready, z_valid, div_by_zero, q, r}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort z_valid in reset", 32'(z_valid), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("aborted result never signalled", 32'(z_valid), 32'd0);
    end
    v = '{8'd13, 4'd4, 8'd3, 4'd1, 1'b0, 0, 1'b0};
    run_op(v, "after abort 13/4");

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sequential_div.md
Name: sequential_div

Overview:
Multi-cycle restoring divider. It is the inverse datapath to the sequential multiplier and uses the same ab_valid/ab_ready input handshake and z_valid result signalling, plus a z_ready output back-pressure. It computes one quotient bit per clock, so area stays minimal. It sits in the arithmetic unit next to the multiplier, where the shared handshake lets either unit be placed behind the same issue logic.

Parameters:
Dividend_length, 8, width of dividend a and of quotient q.
Divisor_length, 4, width of divisor b and of remainder r.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
a  input  Dividend_length  dividend, unsigned.
b  input  Divisor_length  divisor, unsigned.
ab_valid  input  1  a/b valid.
ab_ready  output  1  divider idle and able to accept a/b.
q  output  Dividend_length  quotient.
r  output  Divisor_length  remainder.
div_by_zero  output  1  result was produced with b==0.
z_valid  output  1  q/r/div_by_zero valid.
z_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async, active-high): state=IDLE, ab_ready=0, z_valid=0, q=0, r=0, div_by_zero=0, and all internal registers cleared.
- ab_ready is registered. It goes to 1 on the first rising edge after rst deasserts, and is 1 only while the state is IDLE.
- States are IDLE, CALC, DONE.
- IDLE:
  - Accept occurs on an edge where ab_valid && ab_ready.
  - On accept, latch a, b, clear the partial remainder (Divisor_length+1 bits), load count=Dividend_length, and drop ab_ready.
  - If b!=0, go to CALC. If b==0, go to DONE with q=all ones, r=0, div_by_zero=1.
- CALC, one iteration per edge, MSB of the dividend first:
  - Shift the dividend MSB into the partial remainder.
  - Trial-subtract b. If the result is non-negative, keep the difference and set quotient bit=1. Otherwise restore and set quotient bit=0.
  - Decrement count. The edge that processes the last bit loads q and r and enters DONE with z_valid=1 and div_by_zero=0.
- Latency:
  - b!=0: z_valid is high Dividend_length edges after the accept edge.
  - b==0: z_valid is high 1 edge after the accept edge.
- DONE: z_valid=1. q, r and div_by_zero are held stable while z_ready=0.
  - On an edge with z_ready=1: z_valid=0, ab_ready=1, state=IDLE.
  - q and r keep their last value after release. They are only meaningful while z_valid=1.
- Back-to-back: a new accept is possible on the edge after release, so minimum issue spacing is Dividend_length+2 cycles.
- Inputs a and b are sampled only at accept. Changes to a, b or ab_valid during CALC or DONE are ignored.
- ab_valid may be high while ab_ready=0. Nothing is accepted and the request is not lost; upstream must hold it.
- z_ready high outside DONE has no effect.
- Arithmetic: unsigned only. Invariant a == q*b + r with r < b for b!=0.
- rst asserted mid-CALC or mid-DONE aborts immediately to the reset values. The in-flight result is discarded and never signalled.

Test Plan:
- Reset then idle: assert rst for 3 cycles with ab_valid=1 -> all outputs 0 during reset; ab_ready=1 one edge after release.
- Basic divide: a=200, b=7 -> after 8 edges z_valid=1, q=28, r=4, div_by_zero=0; z_ready=1 releases and ab_ready=1 on the same edge.
- Boundaries:
  - a=255, b=15 -> q=17, r=0.
  - a=5, b=9 -> q=0, r=5.
  - a=0, b=3 -> q=0, r=0.
  - a=255, b=1 -> q=255, r=0.
- Divide by zero: a=100, b=0 -> z_valid 1 edge after accept, q=255, r=0, div_by_zero=1.
- Back-pressure and input stability:
  - Hold z_ready=0 for 5 cycles in DONE -> q/r stay stable and z_valid stays 1.
  - Toggle a, b and ab_valid during CALC -> result unchanged and no second accept.
  - Back-to-back ops 100/3 then 99/10 -> (33,1) then (9,9).
- Reset mid-operation: assert rst 4 edges into CALC for 200/7 -> outputs cleared immediately, no z_valid pulse; a following 13/4 gives q=3, r=1.
